// File: rtl/load_queue.sv
// Load queue between dispatch and the memory unit.
// Buffers up to DEPTH loads, snoops the CDB for pending base operands and
// issues the oldest address-ready load through a registered valid/ready port.
module load_queue #(
    parameter int DEPTH    = 4,
    parameter int ROB_IX_W = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        valid_input_in,
    output logic                        ready_out,
    input  logic [ROB_IX_W-1:0]         rob_ix_in,
    input  logic [2:0]                  funct3_in,
    input  logic                        base_valid_in,
    input  logic [31:0]                 base_in,
    input  logic [ROB_IX_W-1:0]         base_tag_in,
    input  logic [31:0]                 imm_in,
    input  logic                        cdb_valid_in,
    input  logic [ROB_IX_W-1:0]         cdb_tag_in,
    input  logic [31:0]                 cdb_data_in,
    input  logic                        flush_in,
    output logic                        mem_req_valid_out,
    input  logic                        mem_req_ready_in,
    output logic [31:0]                 mem_addr_out,
    output logic [2:0]                  mem_funct3_out,
    output logic [ROB_IX_W-1:0]         mem_rob_ix_out,
    output logic [$clog2(DEPTH+1)-1:0]  count_out
);

    localparam int IX_W  = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ENTRY_FREE,
        ENTRY_WAIT,
        ENTRY_READY
    } entry_state_e;

    // Age is a dense rank among occupied entries: 0 is the oldest.
    entry_state_e        state_q   [DEPTH];
    entry_state_e        state_d   [DEPTH];
    logic [IX_W-1:0]     age_q     [DEPTH];
    logic [IX_W-1:0]     age_d     [DEPTH];
    logic [31:0]         base_q    [DEPTH];
    logic [ROB_IX_W-1:0] tag_q     [DEPTH];
    logic [31:0]         imm_q     [DEPTH];
    logic [2:0]          funct3_q  [DEPTH];
    logic [ROB_IX_W-1:0] rob_ix_q  [DEPTH];

    logic                out_valid_q;
    logic [31:0]         out_addr_q;
    logic [2:0]          out_funct3_q;
    logic [ROB_IX_W-1:0] out_rob_ix_q;

    logic                has_free;
    logic [IX_W-1:0]     alloc_ix;
    logic                has_ready;
    logic [IX_W-1:0]     issue_ix;
    logic [IX_W-1:0]     issue_age;
    logic [CNT_W-1:0]    occupied;
    logic                load_out;
    logic                do_issue;
    logic                do_alloc;
    logic                dispatch_bypass;
    logic [CNT_W-1:0]    new_age_w;
    logic [DEPTH-1:0]    alloc_sel;
    logic [DEPTH-1:0]    capture_sel;

    // Scan current state: lowest free slot, oldest ready entry, occupancy.
    always_comb begin
        has_free  = 1'b0;
        alloc_ix  = '0;
        has_ready = 1'b0;
        issue_ix  = '0;
        issue_age = '0;
        occupied  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ENTRY_FREE) begin
                has_free = 1'b1;
                alloc_ix = IX_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != ENTRY_FREE) begin
                occupied = occupied + 1'b1;
            end
            if (state_q[i] == ENTRY_READY && (!has_ready || age_q[i] < issue_age)) begin
                has_ready = 1'b1;
                issue_ix  = IX_W'(i);
                issue_age = age_q[i];
            end
        end
    end

    // Decide whether the output register refills and whether dispatch is taken.
    always_comb begin
        load_out        = !out_valid_q || mem_req_ready_in;
        do_issue        = load_out && has_ready && !flush_in;
        do_alloc        = valid_input_in && has_free && !flush_in;
        dispatch_bypass = !base_valid_in && cdb_valid_in && (cdb_tag_in == base_tag_in);
        new_age_w       = occupied - CNT_W'(do_issue);
    end

    // Next state per entry: CDB wakeup, issue release with age compaction, allocation.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i]     = state_q[i];
            age_d[i]       = age_q[i];
            alloc_sel[i]   = 1'b0;
            capture_sel[i] = 1'b0;
            if (flush_in) begin
                state_d[i] = ENTRY_FREE;
            end else begin
                if (state_q[i] == ENTRY_WAIT && cdb_valid_in && tag_q[i] == cdb_tag_in) begin
                    state_d[i]     = ENTRY_READY;
                    capture_sel[i] = 1'b1;
                end
                if (do_issue) begin
                    if (issue_ix == IX_W'(i)) begin
                        state_d[i] = ENTRY_FREE;
                    end else if (state_q[i] != ENTRY_FREE && age_q[i] > issue_age) begin
                        age_d[i] = age_q[i] - 1'b1;
                    end
                end
                if (do_alloc && alloc_ix == IX_W'(i)) begin
                    state_d[i]   = (base_valid_in || dispatch_bypass) ? ENTRY_READY : ENTRY_WAIT;
                    age_d[i]     = new_age_w[IX_W-1:0];
                    alloc_sel[i] = 1'b1;
                end
            end
        end
    end

    // Entry state and age registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ENTRY_FREE;
                age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    // Entry payload: filled on allocation, base refreshed on CDB capture.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_sel[i]) begin
                base_q[i]   <= base_valid_in ? base_in : cdb_data_in;
                tag_q[i]    <= base_tag_in;
                imm_q[i]    <= imm_in;
                funct3_q[i] <= funct3_in;
                rob_ix_q[i] <= rob_ix_in;
            end else if (capture_sel[i]) begin
                base_q[i] <= cdb_data_in;
            end
        end
    end

    // Output register: holds while stalled, otherwise takes the oldest ready load.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_funct3_q <= '0;
            out_rob_ix_q <= '0;
        end else if (flush_in) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= has_ready;
            if (has_ready) begin
                out_addr_q   <= base_q[issue_ix] + imm_q[issue_ix];
                out_funct3_q <= funct3_q[issue_ix];
                out_rob_ix_q <= rob_ix_q[issue_ix];
            end
        end
    end

    // Drive ports from current state only.
    always_comb begin
        ready_out         = has_free;
        count_out         = occupied;
        mem_req_valid_out = out_valid_q;
        mem_addr_out      = out_addr_q;
        mem_funct3_out    = out_funct3_q;
        mem_rob_ix_out    = out_rob_ix_q;
    end

endmodule

// File: tb/tb_load_queue.sv
// Testbench for load_queue: table-driven address vectors plus hand-written
// ordering, wakeup, stall and flush sequences, checked through a scoreboard.
module tb_load_queue;

    localparam int DEPTH    = 4;
    localparam int ROB_IX_W = 3;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                valid_input_in;
    logic                ready_out;
    logic [ROB_IX_W-1:0] rob_ix_in;
    logic [2:0]          funct3_in;
    logic                base_valid_in;
    logic [31:0]         base_in;
    logic [ROB_IX_W-1:0] base_tag_in;
    logic [31:0]         imm_in;
    logic                cdb_valid_in;
    logic [ROB_IX_W-1:0] cdb_tag_in;
    logic [31:0]         cdb_data_in;
    logic                flush_in;
    logic                mem_req_valid_out;
    logic                mem_req_ready_in;
    logic [31:0]         mem_addr_out;
    logic [2:0]          mem_funct3_out;
    logic [ROB_IX_W-1:0] mem_rob_ix_out;
    logic [2:0]          count_out;

    typedef struct {
        logic [31:0]         addr;
        logic [2:0]          funct3;
        logic [ROB_IX_W-1:0] rob_ix;
    } exp_t;

    typedef struct {
        logic [31:0]         base;
        logic [31:0]         imm;
        logic [2:0]          funct3;
        logic [ROB_IX_W-1:0] rob_ix;
        logic [31:0]         exp_addr;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    vec_t vectors[6];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    load_queue #(.DEPTH(DEPTH), .ROB_IX_W(ROB_IX_W)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_input_in    (valid_input_in),
        .ready_out         (ready_out),
        .rob_ix_in         (rob_ix_in),
        .funct3_in         (funct3_in),
        .base_valid_in     (base_valid_in),
        .base_in           (base_in),
        .base_tag_in       (base_tag_in),
        .imm_in            (imm_in),
        .cdb_valid_in      (cdb_valid_in),
        .cdb_tag_in        (cdb_tag_in),
        .cdb_data_in       (cdb_data_in),
        .flush_in          (flush_in),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_addr_out      (mem_addr_out),
        .mem_funct3_out    (mem_funct3_out),
        .mem_rob_ix_out    (mem_rob_ix_out),
        .count_out         (count_out)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleInputs();
        valid_input_in = 1'b0;
        rob_ix_in      = '0;
        funct3_in      = '0;
        base_valid_in  = 1'b0;
        base_in        = '0;
        base_tag_in    = '0;
        imm_in         = '0;
        cdb_valid_in   = 1'b0;
        cdb_tag_in     = '0;
        cdb_data_in    = '0;
        flush_in       = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] addr, input logic [2:0] f3, input logic [ROB_IX_W-1:0] rob);
        exp_t e;
        e.addr   = addr;
        e.funct3 = f3;
        e.rob_ix = rob;
        sb_q.push_back(e);
    endtask

    // Dispatch one load for one clock edge, then drop valid.
    task automatic applyStimulus(input logic bv, input logic [31:0] base, input logic [ROB_IX_W-1:0] tag,
                                 input logic [31:0] imm, input logic [2:0] f3, input logic [ROB_IX_W-1:0] rob);
        valid_input_in = 1'b1;
        base_valid_in  = bv;
        base_in        = base;
        base_tag_in    = tag;
        imm_in         = imm;
        funct3_in      = f3;
        rob_ix_in      = rob;
        step();
        valid_input_in = 1'b0;
        base_valid_in  = 1'b0;
    endtask

    // Scoreboard monitor: each accepted request must match the next expectation.
    always @(negedge clk_in) begin
        if (rst_in === 1'b0 && mem_req_valid_out === 1'b1 && mem_req_ready_in === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_issue: got addr 0x%08h rob %0d, expected no request",
                         mem_addr_out, mem_rob_ix_out);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("issue_addr", mem_addr_out, mon_exp.addr);
                checkOutput("issue_funct3_rob", 32'({mem_funct3_out, mem_rob_ix_out}),
                            32'({mon_exp.funct3, mon_exp.rob_ix}));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vectors[0] = '{32'h0000_2000, 32'h0000_0010, 3'd2, 3'd0, 32'h0000_2010};
        vectors[1] = '{32'hFFFF_FFF0, 32'h0000_0020, 3'd0, 3'd1, 32'h0000_0010};
        vectors[2] = '{32'h0000_0000, 32'h0000_0000, 3'd4, 3'd2, 32'h0000_0000};
        vectors[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd1, 3'd3, 32'h8000_0000};
        vectors[4] = '{32'h1234_5678, 32'hFFFF_FF00, 3'd5, 3'd7, 32'h1234_5578};
        vectors[5] = '{32'h8000_0000, 32'h8000_0000, 3'd2, 3'd5, 32'h0000_0000};

        idleInputs();
        mem_req_ready_in = 1'b1;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(mem_req_valid_out), 32'd0);
        checkOutput("rst_addr", mem_addr_out, 32'd0);
        checkOutput("rst_f3_rob", 32'({mem_funct3_out, mem_rob_ix_out}), 32'd0);
        checkOutput("rst_count", 32'(count_out), 32'd0);
        checkOutput("rst_ready", 32'(ready_out), 32'd1);

        $display("[TB] single load latency");
        pushExp(32'h0000_0FFC, 3'd2, 3'd2);
        applyStimulus(1'b1, 32'h0000_1000, 3'd0, 32'hFFFF_FFFC, 3'd2, 3'd2);
        checkOutput("lat_count_n", 32'(count_out), 32'd1);
        checkOutput("lat_valid_n", 32'(mem_req_valid_out), 32'd0);
        step();
        checkOutput("lat_valid_n1", 32'(mem_req_valid_out), 32'd1);
        checkOutput("lat_addr_n1", mem_addr_out, 32'h0000_0FFC);
        checkOutput("lat_count_n1", 32'(count_out), 32'd0);
        step();
        checkOutput("lat_valid_after", 32'(mem_req_valid_out), 32'd0);

        $display("[TB] address vectors back to back");
        for (int v = 0; v < 6; v++) begin
            pushExp(vectors[v].exp_addr, vectors[v].funct3, vectors[v].rob_ix);
            applyStimulus(1'b1, vectors[v].base, 3'd0, vectors[v].imm, vectors[v].funct3, vectors[v].rob_ix);
        end
        for (int k = 0; k < 4; k++) step();
        checkOutput("vec_count_drained", 32'(count_out), 32'd0);
        checkOutput("vec_valid_drained", 32'(mem_req_valid_out), 32'd0);

        $display("[TB] full queue with pending tags");
        applyStimulus(1'b0, 32'd0, 3'd1, 32'd0, 3'd2, 3'd0);
        applyStimulus(1'b0, 32'd0, 3'd2, 32'd0, 3'd2, 3'd1);
        applyStimulus(1'b0, 32'd0, 3'd3, 32'd0, 3'd2, 3'd2);
        applyStimulus(1'b0, 32'd0, 3'd5, 32'd4, 3'd5, 3'd3);
        checkOutput("full_ready", 32'(ready_out), 32'd0);
        checkOutput("full_count", 32'(count_out), 32'd4);
        applyStimulus(1'b1, 32'h0000_0777, 3'd0, 32'd0, 3'd2, 3'd7);
        checkOutput("full_drop_count", 32'(count_out), 32'd4);
        pushExp(32'h0000_0304, 3'd5, 3'd3);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 3'd5;
        cdb_data_in  = 32'h0000_0300;
        step();
        cdb_valid_in = 1'b0;
        step();
        checkOutput("full_issue_valid", 32'(mem_req_valid_out), 32'd1);
        checkOutput("full_issue_count", 32'(count_out), 32'd3);
        for (int k = 0; k < 4; k++) step();
        checkOutput("full_no_more_issue", 32'(mem_req_valid_out), 32'd0);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        checkOutput("full_cleanup_count", 32'(count_out), 32'd0);

        $display("[TB] younger ready load bypasses waiting load");
        applyStimulus(1'b0, 32'd0, 3'd5, 32'h0000_0008, 3'd0, 3'd4);
        pushExp(32'h0000_0504, 3'd4, 3'd5);
        applyStimulus(1'b1, 32'h0000_0500, 3'd0, 32'h0000_0004, 3'd4, 3'd5);
        step();
        pushExp(32'h0000_0028, 3'd0, 3'd4);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 3'd5;
        cdb_data_in  = 32'h0000_0020;
        step();
        cdb_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checkOutput("order_count", 32'(count_out), 32'd0);

        $display("[TB] dispatch-cycle CDB bypass");
        pushExp(32'h0000_0050, 3'd1, 3'd6);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 3'd4;
        cdb_data_in  = 32'h0000_0040;
        applyStimulus(1'b0, 32'hDEAD_BEEF, 3'd4, 32'h0000_0010, 3'd1, 3'd6);
        cdb_valid_in = 1'b0;
        checkOutput("bypass_count", 32'(count_out), 32'd1);
        step();
        checkOutput("bypass_valid", 32'(mem_req_valid_out), 32'd1);
        checkOutput("bypass_addr", mem_addr_out, 32'h0000_0050);
        for (int k = 0; k < 2; k++) step();

        $display("[TB] stalled output with older load waking");
        mem_req_ready_in = 1'b0;
        pushExp(32'h0000_0900, 3'd2, 3'd2);
        pushExp(32'h0000_0700, 3'd2, 3'd1);
        pushExp(32'h0000_0A00, 3'd1, 3'd3);
        applyStimulus(1'b0, 32'd0, 3'd6, 32'd0, 3'd2, 3'd1);
        applyStimulus(1'b1, 32'h0000_0900, 3'd0, 32'd0, 3'd2, 3'd2);
        applyStimulus(1'b1, 32'h0000_0A00, 3'd0, 32'd0, 3'd1, 3'd3);
        for (int k = 0; k < 10; k++) begin
            checkOutput("stall_valid", 32'(mem_req_valid_out), 32'd1);
            checkOutput("stall_addr", mem_addr_out, 32'h0000_0900);
            checkOutput("stall_rob", 32'(mem_rob_ix_out), 32'd2);
            if (k == 3) begin
                cdb_valid_in = 1'b1;
                cdb_tag_in   = 3'd6;
                cdb_data_in  = 32'h0000_0700;
            end
            step();
            cdb_valid_in = 1'b0;
        end
        mem_req_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) step();
        checkOutput("stall_drained", 32'(count_out), 32'd0);

        $display("[TB] flush with buffered loads and valid output");
        mem_req_ready_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 32'(k) << 8, 3'd0, 32'd0, 3'd2, 3'(k));
        end
        checkOutput("preflush_count", 32'(count_out), 32'd3);
        checkOutput("preflush_valid", 32'(mem_req_valid_out), 32'd1);
        flush_in     = 1'b1;
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 3'd0;
        cdb_data_in  = 32'h0000_0BAD;
        applyStimulus(1'b1, 32'h0000_0F00, 3'd0, 32'd0, 3'd2, 3'd6);
        flush_in     = 1'b0;
        cdb_valid_in = 1'b0;
        checkOutput("flush_valid", 32'(mem_req_valid_out), 32'd0);
        checkOutput("flush_count", 32'(count_out), 32'd0);
        checkOutput("flush_ready", 32'(ready_out), 32'd1);
        mem_req_ready_in = 1'b1;
        for (int k = 0; k < 3; k++) step();
        checkOutput("flush_no_store_count", 32'(count_out), 32'd0);
        checkOutput("flush_no_store_valid", 32'(mem_req_valid_out), 32'd0);

        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
